// File: rtl/pong_pkg.sv
// Shared Pong game-state types and screen geometry for the ball motion stage.
package pong_pkg;

    typedef logic [1:0] state_bits_t;

    typedef enum state_bits_t {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        PLAY   = 2'd2,
        SCORED = 2'd3
    } state_t;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BALL_SIZE = 8;
    localparam int CENTRE_X  = (H_ACTIVE - BALL_SIZE) / 2;
    localparam int CENTRE_Y  = (V_ACTIVE - BALL_SIZE) / 2;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;
    localparam logic UP    = 1'b0;
    localparam logic DOWN  = 1'b1;

endpackage

// File: rtl/frame_tick_sync.sv
// Two-flop synchronizer and rising-edge detector turning the end-of-frame level
// into a single clk-wide pulse per frame.
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic pulse_out
);

    logic       meta_p0;
    logic       sync_p1;
    logic       sync_d_p2;
    logic [1:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            sync_d_p2 <= 1'b0;
            fill      <= 2'd0;
            pulse_out <= 1'b0;
        end else begin
            // stage p0/p1: metastability filter
            meta_p0   <= level_in;
            sync_p1   <= meta_p0;
            // stage p2: edge detect; fill keeps a level that was already high
            // across reset from looking like a fresh rising edge
            sync_d_p2 <= sync_p1;
            if (fill != 2'd3)
                fill <= fill + 2'd1;
            pulse_out <= sync_p1 & ~sync_d_p2 & (fill == 2'd3);
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Pong ball/serve/score state, advanced once per video frame.
// Optional macro BALL_SPEEDUP_EN: step grows by one on each paddle hit.
module ball_motion
    import pong_pkg::*;
#(
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               endofframe,
    input  logic               serve,
    input  logic [9:0]         paddle_l_y,
    input  logic [9:0]         paddle_r_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         game_state,
    output logic               frame_tick
);

    localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES - 1);

    localparam logic signed [10:0] BS      = 11'(BALL_SIZE);
    localparam logic signed [10:0] PH      = 11'(PADDLE_H);
    localparam logic signed [10:0] XL_FACE = 11'(PADDLE_XL + PADDLE_W);
    localparam logic signed [10:0] XR_FACE = 11'(PADDLE_XR);
    localparam logic signed [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]         CX      = 10'(CENTRE_X);
    localparam logic [9:0]         CY      = 10'(CENTRE_Y);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (&s) ? s : s + SCORE_W'(1);
    endfunction

    function automatic logic [9:0] to_pos(input logic signed [10:0] v);
        if (v < 0)
            return 10'd0;
        return v[9:0];
    endfunction

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [9:0]         bx_n, by_n;
    logic               dx, dx_n, dy, dy_n;
    logic [SCORE_W-1:0] sl_n, sr_n;
    logic signed [10:0] sx, sy, pl, pr, step;
    logic               ovl_l, ovl_r, hit_l, hit_r;

    frame_tick_sync u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_in  (endofframe),
        .pulse_out (frame_tick)
    );

`ifdef BALL_SPEEDUP_EN
    localparam logic signed [10:0] STEP_MAX = 11'(2 * SPEED);
    logic signed [10:0] speed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            speed <= 11'(SPEED);
        else if (frame_tick && state_n == WAIT && state != WAIT)
            speed <= 11'(SPEED);
        else if (frame_tick && state == PLAY && (hit_l || hit_r) && speed < STEP_MAX)
            speed <= speed + 11'sd1;
    end

    assign step = speed;
`else
    assign step = 11'(SPEED);
`endif

    assign sx = signed'({1'b0, ball_x});
    assign sy = signed'({1'b0, ball_y});
    assign pl = signed'({1'b0, paddle_l_y});
    assign pr = signed'({1'b0, paddle_r_y});

    // Overlap written as differences so every term stays inside 11 signed bits.
    assign ovl_l = (pl - sy < BS) && (sy - pl < PH);
    assign ovl_r = (pr - sy < BS) && (sy - pr < PH);
    assign hit_l = (dx == LEFT) && (sx >= XL_FACE) && (sx - step < XL_FACE) && ovl_l;
    assign hit_r = (dx == RIGHT) && (sx + BS <= XR_FACE) && (sx + step + BS > XR_FACE) && ovl_r;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bx_n    = ball_x;
        by_n    = ball_y;
        dx_n    = dx;
        dy_n    = dy;
        sl_n    = score_l;
        sr_n    = score_r;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    bx_n = CX;
                    by_n = CY;
                    if (serve) begin
                        state_n = WAIT;
                        cnt_n   = CNT_LOAD;
                    end
                end
                WAIT: begin
                    bx_n = CX;
                    by_n = CY;
                    if (cnt == '0)
                        state_n = PLAY;
                    else
                        cnt_n = cnt - CNT_W'(1);
                end
                PLAY: begin
                    // y and x resolve independently so corner hits apply both rules
                    if (dy == UP) begin
                        if (sy < step) begin
                            by_n = '0;
                            dy_n = DOWN;
                        end else begin
                            by_n = to_pos(sy - step);
                        end
                    end else if (sy + step > Y_MAX) begin
                        by_n = to_pos(Y_MAX);
                        dy_n = UP;
                    end else begin
                        by_n = to_pos(sy + step);
                    end

                    if (dx == LEFT) begin
                        if (hit_l) begin
                            bx_n = to_pos(XL_FACE);
                            dx_n = RIGHT;
                        end else if (sx < step) begin
                            bx_n    = '0;
                            sr_n    = sat_inc(score_r);
                            state_n = SCORED;
                        end else begin
                            bx_n = to_pos(sx - step);
                        end
                    end else begin
                        if (hit_r) begin
                            bx_n = to_pos(XR_FACE - BS);
                            dx_n = LEFT;
                        end else if (sx + step > X_MAX) begin
                            bx_n    = to_pos(X_MAX);
                            sl_n    = sat_inc(score_l);
                            state_n = SCORED;
                        end else begin
                            bx_n = to_pos(sx + step);
                        end
                    end
                end
                SCORED: begin
                    // dx is left as it was at the miss, so the serve heads to the conceder
                    bx_n    = CX;
                    by_n    = CY;
                    cnt_n   = CNT_LOAD;
                    state_n = WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ball_x  <= CX;
            ball_y  <= CY;
            dx      <= RIGHT;
            dy      <= DOWN;
            score_l <= '0;
            score_r <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ball_x  <= bx_n;
            ball_y  <= by_n;
            dx      <= dx_n;
            dy      <= dy_n;
            score_l <= sl_n;
            score_r <= sr_n;
        end
    end

    assign game_state = state;

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Pong game-state stage directly downstream of the vertical line counter.
- Consumes the counter's `endofframe` level and advances ball position, direction, serve state and scores exactly once per video frame.
- Publishes ball coordinates and scores to the pixel renderer, which compares them against hcount/vcount.
- Paddle positions come from the paddle controller. They are synchronous to `clk` and stable during the frame tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BALL_SIZE, 8, ball edge length in pixels (square)
- PADDLE_H, 64, paddle height in lines
- PADDLE_W, 8, paddle width in pixels
- PADDLE_XL, 16, left paddle left edge x
- PADDLE_XR, 616, right paddle left edge x
- SPEED, 2, pixels moved per frame on each axis
- SERVE_FRAMES, 60, frames between serve/score and ball launch
- SCORE_W, 4, score counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- endofframe  in  1  level from the vertical counter, high across end-of-frame lines; asynchronous to clk
- serve  in  1  debounced serve request, synchronous to clk
- paddle_l_y  in  10  left paddle top y
- paddle_r_y  in  10  right paddle top y
- ball_x  out  10  ball left edge x
- ball_y  out  10  ball top edge y
- score_l  out  SCORE_W  left player score
- score_r  out  SCORE_W  right player score
- game_state  out  2  current FSM state, for the renderer and debug
- frame_tick  out  1  one-clk pulse, one per frame

Behaviour:
- Clock and reset: one clock, `clk`. `rst_n` is an asynchronous, active-low reset.
- Reset state:
  - ball_x = (H_ACTIVE-BALL_SIZE)/2 = 316; ball_y = (V_ACTIVE-BALL_SIZE)/2 = 236.
  - Scores 0; state IDLE; dx = right, dy = down.
  - Sync flops 0; frame_tick 0; countdown 0.
- Frame tick:
  - endofframe passes through a 2-flop synchronizer, then a rising-edge detector.
  - frame_tick = sync & ~sync_d, registered. This gives one pulse per frame regardless of how many lines endofframe stays high.
  - All game updates occur only in the cycle frame_tick is high. Latency is endofframe rise to frame_tick in 3 clk; outputs update 1 clk after frame_tick.
- FSM states: IDLE=0, WAIT=1, PLAY=2, SCORED=3.
  - IDLE: ball centred. On a tick with serve=1, go to WAIT and load countdown = SERVE_FRAMES-1.
  - WAIT: ball held centred. Countdown decrements per tick. On a tick with countdown==0, go to PLAY. serve is ignored.
  - PLAY: per tick, x += ±SPEED and y += ±SPEED, with the collision rules below.
  - SCORED: on the next tick, re-centre the ball, load the countdown and go to WAIT. The serve direction dx points toward the player who conceded.
- Arithmetic:
  - All next-position math uses 11-bit signed intermediates. No wrap-around is permitted; every result is clamped to the legal range.
- Walls:
  - Top: if dy=up and y < SPEED, then y = 0 and dy = down.
  - Bottom: if dy=down and y+SPEED > V_ACTIVE-BALL_SIZE, then y = V_ACTIVE-BALL_SIZE and dy = up.
- Left paddle hit:
  - Conditions: dx=left, and x >= PADDLE_XL+PADDLE_W, and x-SPEED < PADDLE_XL+PADDLE_W.
  - Vertical overlap is also required: y+BALL_SIZE > paddle_l_y and y < paddle_l_y+PADDLE_H.
  - Result: x = PADDLE_XL+PADDLE_W, dx = right.
- Right paddle hit (mirror):
  - Conditions: x+BALL_SIZE <= PADDLE_XR and x+SPEED+BALL_SIZE > PADDLE_XR, with vertical overlap against paddle_r_y.
  - Result: x = PADDLE_XR-BALL_SIZE, dx = left.
- Miss:
  - dx=left and x < SPEED: score_r++, x = 0, go to SCORED.
  - dx=right and x+SPEED > H_ACTIVE-BALL_SIZE: score_l++, x = H_ACTIVE-BALL_SIZE, go to SCORED.
- Simultaneous events:
  - A wall and a paddle in the same tick (corner): both apply; x and y are resolved independently.
  - A miss and a wall in the same tick: the wall applies to y and the score still counts.
- Scores saturate at 2^SCORE_W-1; there is no wrap.
- Reset mid-frame: all state clears immediately. The first tick after release requires a fresh endofframe rising edge; a level already high yields no tick.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- When defined:
  - The per-axis step is a register, speed, initialised to SPEED on reset and on every entry to WAIT.
  - Each paddle hit increments speed by 1, saturating at 2*SPEED.
  - All collision equations use speed in place of SPEED.
- When undefined: the step is the constant SPEED and no register exists.

Decomposition:
- Package pong_pkg holds:
  - the state enum (IDLE/WAIT/PLAY/SCORED) and the 2-bit state type;
  - H_ACTIVE, V_ACTIVE and the screen-centre constants;
  - the direction-bit encodings (LEFT=0/RIGHT=1, UP=0/DOWN=1).
- Sub-module frame_tick_sync: 2-flop synchronizer plus rising-edge detector. Ports: clk, rst_n, level_in, pulse_out.

Test Plan:
- Reset and tick generation:
  - Hold rst_n=0, then release: ball_x=316, ball_y=236, scores 0, game_state=0.
  - Drive endofframe high for 9×800 clk, then low: exactly one frame_tick, 3 clk after the rise.
- Serve countdown:
  - serve=1 on a tick in IDLE: game_state=1.
  - After 60 further ticks, game_state=2 and ball_x becomes 318 on the next tick.
- Top wall:
  - Force PLAY with y=1, dy=up, SPEED=2: next tick y=0, dy=down; the following tick y=2.
- Left paddle hit:
  - x=25, dx=left, y=100, paddle_l_y=80: next tick x=24, dx=right.
  - Repeat with paddle_l_y=200: the ball passes the paddle, and score_r=1 once x would go below 0, with game_state=3.
- Saturation:
  - Force 16 right misses with SCORE_W=4: score_l stops at 15.
- Async reset mid-play:
  - Assert rst_n mid-tick while endofframe=1: outputs return to reset values at once.
  - No frame_tick fires until endofframe falls and rises again.
